// File: rtl/ttl_universal_shift_reg_pkg.sv
// Shared definitions for the parametrised TTL successor models.
// Mode encodings are reused by other register/counter chips in the lab set.
package ttl_universal_shift_reg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHR  = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_LOAD = 3'b011,
        MODE_ROTR = 3'b100,
        MODE_ROTL = 3'b101,
        MODE_UP   = 3'b110,
        MODE_DOWN = 3'b111
    } mode_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // Terminal-count detect shared by every cascadable counter model.
    function automatic logic carry_out(input logic       en,
                                       input logic [2:0] mode,
                                       input logic       all_ones,
                                       input logic       all_zero);
        return en && (((mode == MODE_UP) && all_ones) ||
                      ((mode == MODE_DOWN) && all_zero));
    endfunction

endpackage

// File: rtl/ttl_universal_shift_reg.sv
// WIDTH-bit universal shift register / counter: hold, shift, rotate, load,
// up/down count, complementary outputs and ripple carry for cascading.
module ttl_universal_shift_reg
    import ttl_universal_shift_reg_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             dsr,
    input  logic             dsl,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             rco,
    output logic             ser_out_msb,
    output logic             ser_out_lsb
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("ttl_universal_shift_reg: WIDTH out of range 2..32");
    end

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q_q <= INIT;
        end else begin
            q_q <= q_d;
        end
    end

    // SHR moves data toward the MSB (74194 QA->QD); an unknown mode
    // deliberately propagates X into q instead of being masked.
    always_comb begin
        q_d = q_q;
        if (en) begin
            case (mode)
                MODE_HOLD: q_d = q_q;
                MODE_SHR:  q_d = {q_q[WIDTH-2:0], dsr};
                MODE_SHL:  q_d = {dsl, q_q[WIDTH-1:1]};
                MODE_LOAD: q_d = d;
                MODE_ROTR: q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                MODE_ROTL: q_d = {q_q[0], q_q[WIDTH-1:1]};
                MODE_UP:   q_d = q_q + WIDTH'(1);
                MODE_DOWN: q_d = q_q - WIDTH'(1);
                default:   q_d = 'x;
            endcase
        end
    end

    assign q           = q_q;
    assign qn          = ~q_q;
    assign ser_out_msb = q_q[WIDTH-1];
    assign ser_out_lsb = q_q[0];
    assign rco         = carry_out(en, mode, &q_q, ~|q_q);

endmodule
